// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - shares one pipelined 16x8 multiplier among NREQ requesters (option macro: MUL_SHARE_ARB_FIXED_PRI_EN)
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic [15:0]          mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_p,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] gnt_idx;
    logic          gnt_found;
    logic          accept;
    logic [15:0]   sel_a;
    logic [7:0]    sel_b;
    int            lane;

    // One valid bit per multiplier stage plus the response stage; idx rides alongside.
    logic [MUL_LAT:0] tag_v;
    logic [IW-1:0]    tag_idx [MUL_LAT+1];

`ifndef MUL_SHARE_ARB_FIXED_PRI_EN
    logic [IW-1:0] rr_ptr;
`endif

    // Pick the winner: first valid lane scanning upward from the search start.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        lane      = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_SHARE_ARB_FIXED_PRI_EN
            lane = k;
`else
            lane = int'(rr_ptr) + k;
            if (lane >= NREQ) begin
                lane = lane - NREQ;
            end
`endif
            if (!gnt_found && req_valid[lane]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(lane);
            end
        end
    end

    assign accept    = gnt_found & ~hold;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
    assign sel_a     = req_a[int'(gnt_idx)*16 +: 16];
    assign sel_b     = req_b[int'(gnt_idx)*8 +: 8];

    // Operand registers feeding the multiplier; they hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
        end
    end

`ifndef MUL_SHARE_ARB_FIXED_PRI_EN
    // Round-robin pointer moves just past the lane that was served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end
`endif

    // Tag valid bits advance every cycle; the multiplier never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v <= '0;
        end else begin
            tag_v <= {tag_v[MUL_LAT-1:0], accept};
        end
    end

    // Owner indices follow their valid bits; meaningless while the valid bit is low.
    always_ff @(posedge clk) begin
        tag_idx[0] <= gnt_idx;
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
    end

    // Return the product to its owner when the oldest tag is valid; busy tracks post-shift tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= tag_v[MUL_LAT] ? (NREQ'(1) << tag_idx[MUL_LAT]) : '0;
            if (tag_v[MUL_LAT]) begin
                rsp_data <= mul_p;
            end
            busy <= accept | (|tag_v[MUL_LAT-1:0]);
        end
    end

endmodule
